uart_frame_parser: RTL and testbench

- Consumes the byte stream produced by the UART receiver (8-bit data plus a one-cycle valid strobe).
- Delineates command frames of the form 0xAA 0x55 CMD LEN PAYLOAD[LEN] CHK and verifies the additive checksum.
- Presents each validated frame as registered command/length/payload fields with a one-cycle strobe.
- Sits between the UART RX stage and the vending control logic; malformed frames are dropped and reported on an error strobe.

---
 rtl/uart_frame_parser.sv | 178 +++++++++++++++++
 tb/tb_uart_frame_parser.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/uart_frame_parser.sv
// uart_frame_parser
//   Delineates command frames  AA 55 CMD LEN PAYLOAD[LEN] CHK  out of the
//   UART RX byte stream and checks the 8-bit additive checksum, which covers
//   CMD, LEN and the payload bytes.
//   Good frames are latched onto the frame_* outputs with a one-cycle
//   frame_valid pulse. Aborted frames give a one-cycle frame_err pulse, and
//   err_code records the cause.
//
// Ports
//   sys_clk, sys_rst_n   clock, asynchronous active-low reset
//   pi_data, pi_flag     received byte and its one-cycle strobe
//   frame_valid          pulse: frame_cmd/len/payload were just updated
//   frame_cmd/len        CMD and LEN of the last good frame
//   frame_payload        payload of the last good frame, byte i at [8i+7:8i]
//                        (bytes at or beyond LEN read 0)
//   frame_err            pulse: a frame was aborted
//   err_code             last abort cause: 1=checksum 2=LEN>MAX_LEN 3=timeout
//
// TIMEOUT_CYC (CLK_FREQ/1000*TIMEOUT_MS) must be at least 2.
module uart_frame_parser #(
    parameter int CLK_FREQ   = 27_000_000,
    parameter int TIMEOUT_MS = 5,
    parameter int MAX_LEN    = 8
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst_n,
    input  logic [7:0]           pi_data,
    input  logic                 pi_flag,
    output logic                 frame_valid,
    output logic [7:0]           frame_cmd,
    output logic [3:0]           frame_len,
    output logic [8*MAX_LEN-1:0] frame_payload,
    output logic                 frame_err,
    output logic [1:0]           err_code
);

    localparam logic [31:0] TIMEOUT_CYC = 32'(CLK_FREQ / 1000 * TIMEOUT_MS);
    // The counter is compared one step early. The abort is therefore
    // registered on the same edge at which the count would reach
    // TIMEOUT_CYC-1.
    localparam logic [31:0] TO_TERM     = TIMEOUT_CYC - 32'd2;
    localparam logic [7:0]  MAX_LEN_B   = 8'(MAX_LEN);

    typedef enum logic [2:0] {
        S_IDLE, S_HDR2, S_CMD, S_LEN, S_DATA, S_CHK
    } state_t;

    state_t                    state_q, state_d;
    logic [7:0]                cmd_q, cmd_d;
    logic [3:0]                len_q, len_d;
    logic [3:0]                idx_q, idx_d;
    logic [7:0]                sum_q, sum_d;
    logic [MAX_LEN-1:0][7:0]   pay_q, pay_d;
    logic [31:0]               cnt_q, cnt_d;
    logic                      valid_q, valid_d;
    logic                      err_q, err_d;
    logic [1:0]                code_q, code_d;
    logic [7:0]                fcmd_q, fcmd_d;
    logic [3:0]                flen_q, flen_d;
    logic [MAX_LEN-1:0][7:0]   fpay_q, fpay_d;
    logic                      tmo;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= S_IDLE;
            cmd_q   <= '0;
            len_q   <= '0;
            idx_q   <= '0;
            sum_q   <= '0;
            pay_q   <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            code_q  <= '0;
            fcmd_q  <= '0;
            flen_q  <= '0;
            fpay_q  <= '0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            sum_q   <= sum_d;
            pay_q   <= pay_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            code_q  <= code_d;
            fcmd_q  <= fcmd_d;
            flen_q  <= flen_d;
            fpay_q  <= fpay_d;
        end
    end

    // A byte arriving on the terminal-count cycle takes priority, so tmo
    // is qualified with !pi_flag.
    assign tmo = (state_q != S_IDLE) && !pi_flag && (cnt_q == TO_TERM);

    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        len_d   = len_q;
        idx_d   = idx_q;
        sum_d   = sum_q;
        pay_d   = pay_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        code_d  = code_q;
        fcmd_d  = fcmd_q;
        flen_d  = flen_q;
        fpay_d  = fpay_q;

        if (state_q == S_IDLE || pi_flag) cnt_d = '0;
        else                              cnt_d = cnt_q + 32'd1;

        if (tmo) begin
            state_d = S_IDLE;
            err_d   = 1'b1;
            code_d  = 2'd3;
            cnt_d   = '0;
        end else if (pi_flag) begin
            case (state_q)
                S_IDLE: if (pi_data == 8'hAA) state_d = S_HDR2;
                S_HDR2: begin
                    // A repeated AA may be the true start, so stay in HDR2
                    if (pi_data == 8'h55)      state_d = S_CMD;
                    else if (pi_data != 8'hAA) state_d = S_IDLE;
                end
                S_CMD: begin
                    cmd_d   = pi_data;
                    sum_d   = pi_data;
                    pay_d   = '0;
                    state_d = S_LEN;
                end
                S_LEN: begin
                    if (pi_data > MAX_LEN_B) begin
                        err_d   = 1'b1;
                        code_d  = 2'd2;
                        state_d = S_IDLE;
                    end else begin
                        len_d   = pi_data[3:0];
                        sum_d   = sum_q + pi_data;
                        idx_d   = '0;
                        state_d = (pi_data == 8'h00) ? S_CHK : S_DATA;
                    end
                end
                S_DATA: begin
                    for (int i = 0; i < MAX_LEN; i++)
                        if (idx_q == 4'(i)) pay_d[i] = pi_data;
                    sum_d = sum_q + pi_data;
                    idx_d = idx_q + 4'd1;
                    if (idx_q == len_q - 4'd1) state_d = S_CHK;
                end
                S_CHK: begin
                    if (pi_data == sum_q) begin
                        valid_d = 1'b1;
                        fcmd_d  = cmd_q;
                        flen_d  = len_q;
                        fpay_d  = pay_q;
                    end else begin
                        err_d  = 1'b1;
                        code_d = 2'd1;
                    end
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign frame_valid   = valid_q;
    assign frame_err     = err_q;
    assign err_code      = code_q;
    assign frame_cmd     = fcmd_q;
    assign frame_len     = flen_q;
    assign frame_payload = fpay_q;

endmodule

// File: tb/tb_uart_frame_parser.sv
// Directed bench for uart_frame_parser. It uses a short timeout of
// 10000/1000*2 = 20 cycles and MAX_LEN = 8.
// Inputs change on the falling edge. Outputs are sampled on the falling edge.
module tb_uart_frame_parser;

    localparam int T = 20;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic [7:0]  pi_data = 8'h00;
    logic        pi_flag = 1'b0;
    logic        frame_valid, frame_err;
    logic [7:0]  frame_cmd;
    logic [3:0]  frame_len;
    logic [63:0] frame_payload;
    logic [1:0]  err_code;

    int total = 0;
    int bad   = 0;

    uart_frame_parser #(.CLK_FREQ(10_000), .TIMEOUT_MS(2), .MAX_LEN(8)) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
        .pi_data(pi_data), .pi_flag(pi_flag),
        .frame_valid(frame_valid), .frame_cmd(frame_cmd), .frame_len(frame_len),
        .frame_payload(frame_payload), .frame_err(frame_err), .err_code(err_code)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // The call starts at a falling edge. It returns one falling edge later,
    // in the cycle after the byte was sampled.
    task automatic send(input logic [7:0] b);
        pi_data = b;
        pi_flag = 1'b1;
        @(negedge sys_clk);
        pi_flag = 1'b0;
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge sys_clk);
        check("rst_valid", 64'(frame_valid), 64'd0);
        check("rst_err",   64'(frame_err),   64'd0);
        check("rst_code",  64'(err_code),    64'd0);
        check("rst_cmd",   64'(frame_cmd),   64'd0);
        check("rst_len",   64'(frame_len),   64'd0);
        check("rst_pay",   frame_payload,    64'd0);
        sys_rst_n = 1'b1;
        @(negedge sys_clk);

        // Good frame: sum 01+02+10+20 = 33
        send(8'hAA); send(8'h55); send(8'h01); send(8'h02); send(8'h10); send(8'h20);
        check("good_early_valid", 64'(frame_valid), 64'd0);
        send(8'h33);
        check("good_valid", 64'(frame_valid), 64'd1);
        check("good_err",   64'(frame_err),   64'd0);
        check("good_cmd",   64'(frame_cmd),   64'h01);
        check("good_len",   64'(frame_len),   64'd2);
        check("good_pay",   frame_payload,    64'h0000_0000_0000_2010);
        @(negedge sys_clk);
        check("good_pulse_end", 64'(frame_valid), 64'd0);

        // Bad checksum: the previous frame outputs must stay unchanged
        send(8'hAA); send(8'h55); send(8'h01); send(8'h02); send(8'h10); send(8'h20);
        send(8'h34);
        check("badchk_err",   64'(frame_err),   64'd1);
        check("badchk_code",  64'(err_code),    64'd1);
        check("badchk_valid", 64'(frame_valid), 64'd0);
        check("badchk_cmd",   64'(frame_cmd),   64'h01);
        check("badchk_pay",   frame_payload,    64'h0000_0000_0000_2010);
        @(negedge sys_clk);
        check("badchk_pulse_end", 64'(frame_err), 64'd0);
        check("badchk_code_hold", 64'(err_code),  64'd1);

        // Oversize LEN (9 > 8)
        send(8'hAA); send(8'h55); send(8'h05); send(8'h09);
        check("oversize_err",  64'(frame_err), 64'd1);
        check("oversize_code", 64'(err_code),  64'd2);
        // Zero LEN: sum 05+00 = 05. AA lands on the error cycle.
        send(8'hAA); send(8'h55); send(8'h05); send(8'h00); send(8'h05);
        check("zlen_valid", 64'(frame_valid), 64'd1);
        check("zlen_cmd",   64'(frame_cmd),   64'h05);
        check("zlen_len",   64'(frame_len),   64'd0);
        check("zlen_pay",   frame_payload,    64'd0);

        // Back-to-back: AA sent in the frame_valid cycle, then a timeout after
        // CMD. The error appears T-1 falling edges after the last send returns.
        send(8'hAA); send(8'h55); send(8'h07);
        repeat (T - 2) @(negedge sys_clk);
        check("tmo_not_early", 64'(frame_err), 64'd0);
        @(negedge sys_clk);
        check("tmo_err",  64'(frame_err), 64'd1);
        check("tmo_code", 64'(err_code),  64'd3);
        check("tmo_cmd_kept", 64'(frame_cmd), 64'h05);
        @(negedge sys_clk);

        // A byte on the terminal-count cycle wins: sum 07+01+02 = 0A
        send(8'hAA); send(8'h55); send(8'h07);
        repeat (T - 2) @(negedge sys_clk);
        send(8'h01);
        check("edge_no_err", 64'(frame_err), 64'd0);
        send(8'h02); send(8'h0A);
        check("edge_valid", 64'(frame_valid), 64'd1);
        check("edge_cmd",   64'(frame_cmd),   64'h07);
        check("edge_pay",   frame_payload,    64'h0000_0000_0000_0002);

        // Resync through garbage. Sum FF+01+80 wraps to 80.
        send(8'h00); send(8'hAA); send(8'hAA); send(8'h55);
        send(8'hFF); send(8'h01); send(8'h80); send(8'h80);
        check("resync_valid", 64'(frame_valid), 64'd1);
        check("resync_cmd",   64'(frame_cmd),   64'hFF);
        check("resync_len",   64'(frame_len),   64'd1);
        check("resync_pay",   frame_payload,    64'h0000_0000_0000_0080);

        // Reset mid-frame clears the outputs asynchronously
        send(8'hAA); send(8'h55); send(8'h01);
        #2 sys_rst_n = 1'b0;
        #1;
        check("midrst_cmd",   64'(frame_cmd),   64'd0);
        check("midrst_len",   64'(frame_len),   64'd0);
        check("midrst_pay",   frame_payload,    64'd0);
        check("midrst_code",  64'(err_code),    64'd0);
        check("midrst_valid", 64'(frame_valid), 64'd0);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        @(negedge sys_clk);
        send(8'hAA); send(8'h55); send(8'h01); send(8'h02); send(8'h10); send(8'h20);
        send(8'h33);
        check("postrst_valid", 64'(frame_valid), 64'd1);
        check("postrst_err",   64'(frame_err),   64'd0);
        check("postrst_pay",   frame_payload,    64'h0000_0000_0000_2010);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
